serial_subtractor: RTL

Bit-serial W-bit subtractor computing `A - B - Bin` one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse-direction counterpart to the team's combinational ripple adders: it produces a difference and borrow-out where those produce a sum and carry-out. It targets area-constrained datapaths where W cycles of latency is acceptable.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Optional signed-overflow output is controlled by SERIAL_SUB_OVF_EN.
interface serial_subtractor_if #(
  parameter int unsigned W = 4
);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;

  modport master (output start, A, B, Bin, input busy, done, Diff, Bout, ovf);
  modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout, ovf);
`else
  modport master (output start, A, B, Bin, input busy, done, Diff, Bout);
  modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Start/busy/done handshake; one result every W+2 cycles at best.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            br_q, br_d;
  logic            bout_q, bout_d;
  logic            a_bit, b_bit, d_bit, br_next;
`ifdef SERIAL_SUB_OVF_EN
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic            ovf_q, ovf_d;
`endif

  // State and datapath registers; reset clears everything, aborting any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state: capture in IDLE, one full-subtractor step per RUN cycle, publish on last bit.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    a_bit   = a_sh_q[0];
    b_bit   = b_sh_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          a_sh_d  = bus.A;
          b_sh_d  = bus.B;
          br_d    = bus.Bin;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = bus.A[W-1];
          b_msb_d = bus.B[W-1];
`endif
        end
      end
      StRun: begin
        // Difference bits enter at the MSB so bit 0 lands at the LSB after W shifts.
        res_d  = {d_bit, res_q[W-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          diff_d  = res_d;
          bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
          // d_bit is the result MSB on the final step.
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
